// File: rtl/mult_n_by_n_pkg.sv
// Shared types and helpers for the iterative N x N multiplier.
// abs_n works on a zero-extended 64-bit container, so operand widths up to 64 are supported.
package mult_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} mult_state_t;

  // Magnitude of an n-bit value; -2^(n-1) maps to 2^(n-1) as an unsigned n-bit number.
  function automatic logic [63:0] abs_n(input logic [63:0] v, input int unsigned n, input logic sgn);
    logic [63:0] mask;
    logic        msb;
    mask = (n >= 64) ? '1 : ((64'd1 << n) - 64'd1);
    msb  = ((v >> (n - 1)) & 64'd1) != 64'd0;
    if (sgn && msb) abs_n = (~v + 64'd1) & mask;
    else            abs_n = v & mask;
  endfunction

endpackage

// File: rtl/mult_n_by_n_if.sv
// Request/response bundle between the RV32M execute stage and the multiplier.
// master drives the operands and holds start; slave returns done and result.
interface mult_n_by_n_if #(parameter int N = 32);
  logic           is_signed;
  logic           start;
  logic           done;
  logic [N-1:0]   a;
  logic [N-1:0]   b;
  logic [2*N-1:0] result;

  modport master (output is_signed, start, a, b, input done, result);
  modport slave  (input is_signed, start, a, b, output done, result);
endinterface

// File: rtl/mult_n_by_n.sv
// Iterative sign-magnitude N x N -> 2N multiplier, M multiplier bits per cycle with early exit.
// Latency: load edge plus ceil(bitlen(|b|)/M) busy edges; done held while start stays high, start drop aborts.
module mult_n_by_n
  import mult_pkg::*;
#(
  parameter int N = 32,
  parameter int M = 4
) (
  input  logic          clk_100,
  input  logic          reset,
  mult_n_by_n_if.slave  bus
);

  localparam int SW = $clog2(N) + 1;

  mult_state_t    state, state_nx;
  logic [N-1:0]   ua, ua_nx;
  logic [N-1:0]   ub, ub_nx;
  logic           neg, neg_nx;
  logic [2*N-1:0] acc, acc_nx;
  logic [2*N-1:0] res, res_nx;
  logic           done, done_nx;
  logic [SW-1:0]  shift, shift_nx;

  logic [N-1:0]   a_abs, b_abs;
  logic [N+M-1:0] pp;
  logic [2*N-1:0] acc_sum;
  logic [N-1:0]   ub_shr;

  assign a_abs   = N'(abs_n(64'(bus.a), N, bus.is_signed));
  assign b_abs   = N'(abs_n(64'(bus.b), N, bus.is_signed));
  assign pp      = {{M{1'b0}}, ua} * {{N{1'b0}}, ub[M-1:0]};
  assign acc_sum = acc + ({{(N-M){1'b0}}, pp} << shift);
  assign ub_shr  = ub >> M;

  always_comb begin
    state_nx = state;
    ua_nx    = ua;
    ub_nx    = ub;
    neg_nx   = neg;
    acc_nx   = acc;
    res_nx   = res;
    done_nx  = done;
    shift_nx = shift;
    case (state)
      IDLE: begin
        done_nx = 1'b0;
        if (bus.start) begin
          ua_nx    = a_abs;
          ub_nx    = b_abs;
          neg_nx   = bus.is_signed & (bus.a[N-1] ^ bus.b[N-1]);
          acc_nx   = '0;
          shift_nx = '0;
          // A zero operand needs no iteration and cannot produce a negative result.
          if (a_abs == '0 || b_abs == '0) begin
            res_nx   = '0;
            done_nx  = 1'b1;
            state_nx = DONE;
          end else begin
            state_nx = BUSY;
          end
        end
      end
      BUSY: begin
        if (!bus.start) begin
          done_nx  = 1'b0;
          state_nx = IDLE;
        end else begin
          acc_nx   = acc_sum;
          ub_nx    = ub_shr;
          shift_nx = shift + SW'(M);
          if (ub_shr == '0) begin
            res_nx   = neg ? -acc_sum : acc_sum;
            done_nx  = 1'b1;
            state_nx = DONE;
          end
        end
      end
      DONE: begin
        if (!bus.start) begin
          done_nx  = 1'b0;
          state_nx = IDLE;
        end
      end
      default: begin
        done_nx  = 1'b0;
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_100 or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      ua    <= '0;
      ub    <= '0;
      neg   <= 1'b0;
      acc   <= '0;
      res   <= '0;
      done  <= 1'b0;
      shift <= '0;
    end else begin
      state <= state_nx;
      ua    <= ua_nx;
      ub    <= ub_nx;
      neg   <= neg_nx;
      acc   <= acc_nx;
      res   <= res_nx;
      done  <= done_nx;
      shift <= shift_nx;
    end
  end

  assign bus.done   = done;
  assign bus.result = res;

endmodule

// File: tb/tb_mult_n_by_n.sv
// Bench for mult_n_by_n: directed vector table, handshake/reset sequences, random ops vs golden product.
module tb_mult_n_by_n;

  localparam int N    = 32;
  localparam int M    = 4;
  localparam int LMAX = N / M;

  logic clk_100 = 1'b0;
  logic reset;
  always #5 clk_100 = ~clk_100;

  mult_n_by_n_if #(.N(N)) bus ();
  mult_n_by_n #(.N(N), .M(M)) dut (.clk_100(clk_100), .reset(reset), .bus(bus));

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [63:0] r;
    int          cyc;
  } vec_t;

  int          checks   = 0;
  int          failures = 0;
  logic [63:0] sb_q[$];
  int          hist[LMAX+2];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  function automatic logic [63:0] golden(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic signed [63:0] sa, sb;
    if (s) begin
      sa = $signed({{32{a[31]}}, a});
      sb = $signed({{32{b[31]}}, b});
      return 64'(sa * sb);
    end
    return {32'd0, a} * {32'd0, b};
  endfunction

  // Edges from the load edge (counted as 1) to done: 1 + ceil(bitlen(|b|)/M), or 1 for a zero operand.
  function automatic int exp_cycles(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic [31:0] ma, mb;
    int bl;
    ma = (s && a[31]) ? -a : a;
    mb = (s && b[31]) ? -b : b;
    if (ma == 0 || mb == 0) return 1;
    bl = 0;
    for (int i = 0; i < 32; i++) if (mb[i]) bl = i + 1;
    return (bl + M - 1) / M + 1;
  endfunction

  task automatic run_op(input string nm, input logic [31:0] a, input logic [31:0] b, input logic s,
                        input logic [63:0] exp_r, input int exp_cyc, input int hold);
    int          cyc;
    logic        got;
    logic [63:0] exp_q, res_q;
    sb_q.push_back(exp_r);
    @(negedge clk_100);
    bus.a = a; bus.b = b; bus.is_signed = s; bus.start = 1'b1;
    cyc = 0; got = 1'b0;
    while (!got && cyc < 3 * LMAX) begin
      @(posedge clk_100); cyc++;
      @(negedge clk_100);
      if (bus.done) got = 1'b1;
    end
    // Operands change after the load edge must not disturb the result.
    bus.a = ~a; bus.b = ~b; bus.is_signed = ~s;
    exp_q = sb_q.pop_front();
    if (!got) begin
      checks++; failures++;
      $display("FAIL %s timeout actual=no_done required=done", nm);
    end else begin
      res_q = bus.result;
      chk({nm, "_result"}, res_q, exp_q);
      chk({nm, "_cycles"}, 64'(cyc), 64'(exp_cyc));
      chk({nm, "_bound"}, 64'(cyc <= LMAX + 1), 64'd1);
      if (cyc <= LMAX + 1) hist[cyc]++;
      for (int h = 0; h < hold; h++) begin
        @(posedge clk_100); @(negedge clk_100);
        chk({nm, "_hold_done"}, 64'(bus.done), 64'd1);
        chk({nm, "_hold_result"}, bus.result, exp_q);
      end
    end
    bus.start = 1'b0;
    @(posedge clk_100); @(negedge clk_100);
    chk({nm, "_drop_done"}, 64'(bus.done), 64'd0);
    if (got) chk({nm, "_drop_result"}, bus.result, exp_q);
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[13];
    logic [31:0] ra, rb;
    logic        rs;

    vecs[0]  = '{32'd0,          32'd12345678,   1'b0, 64'd0,                   1};
    vecs[1]  = '{32'd9,          32'd3,          1'b0, 64'd27,                  2};
    vecs[2]  = '{32'he35,        32'h352,        1'b0, 64'd3091450,             4};
    vecs[3]  = '{32'd12345,      32'd6789,       1'b0, 64'd83810205,            5};
    vecs[4]  = '{32'd666,        32'd0,          1'b0, 64'd0,                   1};
    vecs[5]  = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b0, 64'hFFFF_FFFE_0000_0001, 9};
    vecs[6]  = '{32'd1,          32'h8000_0000,  1'b0, 64'h0000_0000_8000_0000, 9};
    vecs[7]  = '{32'd17,         32'd5,          1'b1, 64'd85,                  2};
    vecs[8]  = '{32'd17,         32'hFFFF_FFFB,  1'b1, 64'hFFFF_FFFF_FFFF_FFAB, 2};
    vecs[9]  = '{32'hFFFF_FFEF,  32'd5,          1'b1, 64'hFFFF_FFFF_FFFF_FFAB, 2};
    vecs[10] = '{32'hFFFF_FFEF,  32'hFFFF_FFFB,  1'b1, 64'd85,                  2};
    vecs[11] = '{32'h8000_0000,  32'h8000_0000,  1'b1, 64'h4000_0000_0000_0000, 9};
    vecs[12] = '{32'hFFFF_FFFF,  32'd0,          1'b1, 64'd0,                   1};

    for (int i = 0; i < LMAX + 2; i++) hist[i] = 0;
    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.is_signed = 1'b0;
    reset = 1'b1;
    repeat (50) @(posedge clk_100);
    @(negedge clk_100);
    chk("reset_done", 64'(bus.done), 64'd0);
    chk("reset_result", bus.result, 64'd0);
    reset = 1'b0;
    @(posedge clk_100); @(negedge clk_100);
    chk("post_reset_done", 64'(bus.done), 64'd0);

    for (int i = 0; i < 13; i++)
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].r, vecs[i].cyc, (i == 3) ? 3 : 0);

    // Abort: drop start mid-BUSY, previous result (vec12 = 0, so first load 9*3) must survive.
    run_op("pre_abort", 32'd9, 32'd3, 1'b0, 64'd27, 2, 0);
    @(negedge clk_100);
    bus.a = 32'hFFFF_FFFF; bus.b = 32'hFFFF_FFFF; bus.is_signed = 1'b0; bus.start = 1'b1;
    repeat (3) @(posedge clk_100);
    @(negedge clk_100);
    bus.start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk_100); @(negedge clk_100);
      chk("abort_done", 64'(bus.done), 64'd0);
    end
    chk("abort_result", bus.result, 64'd27);
    run_op("post_abort", 32'd12345, 32'd6789, 1'b0, 64'd83810205, 5, 0);

    // Asynchronous reset in the middle of an operation.
    @(negedge clk_100);
    bus.a = 32'hFFFF_FFFF; bus.b = 32'hFFFF_FFFF; bus.is_signed = 1'b0; bus.start = 1'b1;
    repeat (3) @(posedge clk_100);
    #2;
    reset = 1'b1;
    #1;
    chk("midbusy_reset_done", 64'(bus.done), 64'd0);
    chk("midbusy_reset_result", bus.result, 64'd0);
    @(negedge clk_100);
    bus.start = 1'b0;
    @(negedge clk_100);
    reset = 1'b0;
    run_op("post_reset", 32'he35, 32'h352, 1'b0, 64'd3091450, 4, 0);

    for (int sg = 0; sg < 2; sg++) begin
      for (int n = 0; n < 1000; n++) begin
        rs = sg[0];
        ra = $urandom >> $urandom_range(0, 31);
        rb = $urandom >> $urandom_range(0, 31);
        if (rs && $urandom_range(0, 1) == 1) ra = -ra;
        if (rs && $urandom_range(0, 1) == 1) rb = -rb;
        if ($urandom_range(0, 49) == 0) ra = '0;
        if ($urandom_range(0, 49) == 0) rb = '0;
        run_op($sformatf("rnd_s%0d_%0d", sg, n), ra, rb, rs, golden(ra, rb, rs), exp_cycles(ra, rb, rs), 0);
      end
    end

    for (int i = 1; i < LMAX + 2; i++) $display("cycles-to-done %0d: %0d ops", i, hist[i]);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
